// File: rtl/nn_seq_pkg.sv
// Shared types for the layer sequencer: FSM state encoding, per-layer config entry, ceil_div helper.
// Pure declarations: no latency, no flow control.
package nn_seq_pkg;

  localparam int SEQ_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_BIAS,
    S_WB,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [SEQ_CNT_W-1:0] fan_in;
    logic [SEQ_CNT_W-1:0] fan_out;
  } layer_cfg_t;

  // Zero divisor yields zero rather than an undefined result.
  function automatic logic [SEQ_CNT_W-1:0] ceil_div(input logic [SEQ_CNT_W-1:0] num,
                                                   input logic [SEQ_CNT_W-1:0] den);
    logic [SEQ_CNT_W:0] sum;
    if (den == '0) return '0;
    sum = {1'b0, num} + {1'b0, den} - (SEQ_CNT_W+1)'(1);
    return SEQ_CNT_W'(sum / {1'b0, den});
  endfunction

endpackage

// File: rtl/nn_cfg_table.sv
// Per-layer fan-in/fan-out register file: synchronous write, asynchronous read, cleared on reset.
// Write lands on the next clock edge; reads are combinational; no backpressure.
module nn_cfg_table
  import nn_seq_pkg::*;
#(
  parameter int MAX_LAYERS = 8,
  parameter int IDX_W      = $clog2(MAX_LAYERS)
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  layer_cfg_t       wdat,
  input  logic [IDX_W-1:0] raddr,
  output layer_cfg_t       rdat
);

  layer_cfg_t tbl_q [MAX_LAYERS];
  layer_cfg_t tbl_d [MAX_LAYERS];

  always_comb begin
    tbl_d = tbl_q;
    if (we && (int'(waddr) < MAX_LAYERS)) tbl_d[waddr] = wdat;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < MAX_LAYERS; i++) tbl_q[i] <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign rdat = (int'(raddr) < MAX_LAYERS) ? tbl_q[raddr] : '0;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Multi-layer FC inference sequencer over a LANES-wide PE row; per layer passes*(fan_in+2) cycles.
// stall freezes only FEED (address, k, state); start is only honoured in IDLE.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int MAX_LAYERS = 8,
  parameter int CNT_W      = SEQ_CNT_W,
  parameter int LANES      = 2,
  parameter int W          = 10,
  parameter int B          = 6,
  localparam int NL_W      = $clog2(MAX_LAYERS + 1),
  localparam int LI_W      = $clog2(MAX_LAYERS)
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             start,
  input  logic [NL_W-1:0]  num_layers,
  input  logic             stall,
  input  logic             cfg_we,
  input  logic [LI_W-1:0]  cfg_layer,
  input  logic [CNT_W-1:0] cfg_fan_in,
  input  logic [CNT_W-1:0] cfg_fan_out,
  output logic             busy,
  output logic             done,
  output logic             w_rd_en,
  output logic [W-1:0]     w_mem_addr,
  output logic             b_rd_en,
  output logic [B-1:0]     b_mem_addr,
  output logic             acc_en,
  output logic             acc_clr,
  output logic             out_wr,
  output logic [LANES-1:0] lane_valid,
  output logic [LI_W-1:0]  layer_idx,
  output logic             input_layer,
  output logic             output_layer
);

  seq_state_t       state_q, state_d;
  logic [NL_W-1:0]  num_layers_q, num_layers_d;
  logic [LI_W-1:0]  layer_q, layer_d;
  logic [CNT_W-1:0] nb_q, nb_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [W-1:0]     w_addr_q, w_addr_d;
  logic [B-1:0]     b_addr_q, b_addr_d;
  logic             acc_en_q, acc_en_d;

  layer_cfg_t       cfg_wdat, cfg_rdat;
  logic [CNT_W-1:0] fan_in_eff, fan_out_eff;
  logic [NL_W-1:0]  nl_clamped;
  logic             in_pass, last_pass, last_layer, k_last;

  assign cfg_wdat = '{fan_in: SEQ_CNT_W'(cfg_fan_in), fan_out: SEQ_CNT_W'(cfg_fan_out)};

  nn_cfg_table #(
    .MAX_LAYERS(MAX_LAYERS),
    .IDX_W     (LI_W)
  ) u_cfg_table (
    .clk   (clk),
    .rst_in(rst_in),
    .we    (cfg_we && (state_q == S_IDLE)),
    .waddr (cfg_layer),
    .wdat  (cfg_wdat),
    .raddr (layer_q),
    .rdat  (cfg_rdat)
  );

  // A cleared table entry (0) must still run one input / one neuron.
  always_comb begin
    fan_in_eff  = CNT_W'(cfg_rdat.fan_in);
    fan_out_eff = CNT_W'(cfg_rdat.fan_out);
    if (fan_in_eff == '0) fan_in_eff = CNT_W'(1);
    if (fan_out_eff == '0) fan_out_eff = CNT_W'(1);
  end

  assign nl_clamped = (int'(num_layers) > MAX_LAYERS) ? NL_W'(MAX_LAYERS) : num_layers;
  assign in_pass    = (state_q == S_FEED) || (state_q == S_BIAS) || (state_q == S_WB);
  assign last_pass  = ({1'b0, nb_q} + (CNT_W+1)'(LANES)) >= {1'b0, fan_out_eff};
  assign last_layer = NL_W'(layer_q) == (num_layers_q - NL_W'(1));
  assign k_last     = k_q == (fan_in_eff - CNT_W'(1));

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_valid[i] = in_pass && (({1'b0, nb_q} + (CNT_W+1)'(i)) < {1'b0, fan_out_eff});
    end
  end

  always_comb begin
    state_d      = state_q;
    num_layers_d = num_layers_q;
    layer_d      = layer_q;
    nb_d         = nb_q;
    k_d          = k_q;
    w_addr_d     = w_addr_q;
    b_addr_d     = b_addr_q;
    acc_en_d     = w_rd_en;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_layers_d = nl_clamped;
          layer_d      = '0;
          nb_d         = '0;
          k_d          = '0;
          w_addr_d     = '0;
          b_addr_d     = '0;
          state_d      = (num_layers == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (!stall) begin
          w_addr_d = w_addr_q + W'(1);
          k_d      = k_q + CNT_W'(1);
          if (k_last) state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        b_addr_d = b_addr_q + B'(1);
        state_d  = S_WB;
      end
      S_WB: begin
        k_d = '0;
        if (!last_pass) begin
          nb_d    = nb_q + CNT_W'(LANES);
          state_d = S_FEED;
        end else if (last_layer) begin
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + LI_W'(1);
          nb_d    = '0;
          state_d = S_FEED;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      num_layers_q <= '0;
      layer_q      <= '0;
      nb_q         <= '0;
      k_q          <= '0;
      w_addr_q     <= '0;
      b_addr_q     <= '0;
      acc_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_layers_q <= num_layers_d;
      layer_q      <= layer_d;
      nb_q         <= nb_d;
      k_q          <= k_d;
      w_addr_q     <= w_addr_d;
      b_addr_q     <= b_addr_d;
      acc_en_q     <= acc_en_d;
    end
  end

  assign busy         = state_q != S_IDLE;
  assign done         = state_q == S_DONE;
  assign w_rd_en      = (state_q == S_FEED) && !stall;
  assign w_mem_addr   = w_addr_q;
  assign b_rd_en      = state_q == S_BIAS;
  assign b_mem_addr   = b_addr_q;
  assign acc_en       = acc_en_q;
  assign acc_clr      = state_q == S_WB;
  assign out_wr       = state_q == S_WB;
  assign layer_idx    = layer_q;
  assign input_layer  = busy && (layer_q == '0);
  assign output_layer = busy && last_layer;

endmodule
